// File: rtl/lcd_cmd_sequencer.sv
// Command-issue stage for the LCD image controller: queues host command codes in a FIFO and
// hands them to the controller one at a time, pacing on busy/done and dropping invalid codes.
module lcd_cmd_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    host_cmd,
    input  logic          host_valid,
    output logic          host_ready,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          done,
    output logic [AW:0]   fifo_count,
    output logic          cmd_err,
    output logic          frame_done
);

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StWaitDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;
    logic          frame_done_q, frame_done_d;
    logic          push, pop;
    logic [3:0]    head;

    assign host_ready = (count_q != (AW+1)'(DEPTH));
    assign push       = host_valid && host_ready;
    assign head       = mem_q[rd_ptr_q];

    // Storage carries no reset; the pointers alone define what is queued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host_cmd;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        cmd_err_d    = 1'b0;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!busy && (count_q != '0)) begin
                    pop = 1'b1;
                    if (head < 4'd12) begin
                        cmd_d       = head;
                        cmd_valid_d = 1'b1;
                        state_d     = StIssue;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                state_d = (cmd_q == 4'd0) ? StWaitDone : StGap;
            end
            StGap: begin
                state_d = StIdle;
            end
            StWaitDone: begin
                if (done) begin
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cmd_q        <= 4'd0;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
            frame_done_q <= frame_done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_err    = cmd_err_q;
    assign frame_done = frame_done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: stimulus queues expected codes, a negedge monitor
// pops and compares on every cmd_valid / cmd_err.
module tb_lcd_cmd_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    host_cmd;
    logic          host_valid;
    logic          host_ready;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   fifo_count;
    logic          cmd_err;
    logic          frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int last_push_cyc = 0;
    int sb[$];
    int issue_cyc[$];
    bit prev_cv = 1'b0;

    lcd_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count),
        .cmd_err    (cmd_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented command or error pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_count > (AW+1)'(DEPTH)) chk("fifo_count_bound", int'(fifo_count), DEPTH);
            if (cmd_valid && prev_cv) chk("cmd_valid_width", 2, 1);
            if (cmd_valid || cmd_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", int'(cmd), -1);
                end else begin
                    int exp;
                    exp = sb.pop_front();
                    if (exp >= 12) begin
                        chk("err_pulse", int'(cmd_err), 1);
                        chk("no_cv_on_err", int'(cmd_valid), 0);
                    end else begin
                        chk("cmd_valid", int'(cmd_valid), 1);
                        chk("cmd", int'(cmd), exp);
                        chk("no_err_on_cmd", int'(cmd_err), 0);
                    end
                end
                if (cmd_valid) begin
                    issue_cyc.push_back(cyc);
                    issue_cnt++;
                end
            end
            prev_cv = cmd_valid;
        end else begin
            prev_cv = 1'b0;
        end
    end

    task automatic push(input logic [3:0] code, input bit acc);
        host_cmd   = code;
        host_valid = 1'b1;
        chk("host_ready_at_push", int'(host_ready), int'(acc));
        if (acc) sb.push_back(int'(code));
        @(posedge clk);
        #1;
        host_valid    = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic push_hs(input logic [3:0] code);
        int n;
        n          = 0;
        host_cmd   = code;
        host_valid = 1'b1;
        while (!host_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            chk("push_hs_timeout", n, 0);
        end else begin
            sb.push_back(int'(code));
            @(posedge clk);
            #1;
        end
        host_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_remaining", sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        reset      = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        host_valid = 1'b0;
        host_cmd   = 4'd0;

        // Reset values, then a long busy phase with commands held back.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_host_ready", int'(host_ready), 1);
        repeat (70) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(4'd3, 1'b1);
        push(4'd4, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_fifo_count", int'(fifo_count), 2);
        chk("hold_no_issue", issue_cnt, 0);
        issue_cyc.delete();
        busy = 1'b0;
        drain(20);
        if (issue_cyc.size() == 2) chk("issue_spacing", issue_cyc[1] - issue_cyc[0], 3);
        else chk("issue_count_hold", issue_cyc.size(), 2);

        // Fill to full with busy high; the 17th offer is refused.
        busy = 1'b1;
        for (int i = 0; i < 17; i++) push(4'(1 + i % 11), i < 16);
        chk("full_fifo_count", int'(fifo_count), 16);
        chk("full_host_ready", int'(host_ready), 0);
        busy = 1'b0;
        drain(100);
        chk("empty_after_fill", int'(fifo_count), 0);

        // Invalid code between two valid ones; also push-to-issue latency.
        issue_cyc.delete();
        push(4'd5, 1'b1);
        base = last_push_cyc;
        push(4'd13, 1'b1);
        push(4'd6, 1'b1);
        drain(20);
        if (issue_cyc.size() == 2) begin
            chk("push_to_issue_latency", issue_cyc[0] - base, 1);
            chk("invalid_costs_one_cycle", issue_cyc[1] - issue_cyc[0], 4);
        end else begin
            chk("issue_count_invalid", issue_cyc.size(), 2);
        end

        // Write command waits for done; a later command is held until then.
        base = issue_cnt;
        push(4'd9, 1'b1);
        push(4'd0, 1'b1);
        push(4'd1, 1'b1);
        n = 0;
        while (issue_cnt < base + 2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("write_issued", issue_cnt - base, 2);
        busy = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        chk("wait_done_no_issue", issue_cnt - base, 2);
        chk("cmd_hold_zero", int'(cmd), 0);
        chk("no_frame_done_early", int'(frame_done), 0);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        chk("frame_done_pulse", int'(frame_done), 1);
        @(posedge clk);
        #1;
        chk("frame_done_width", int'(frame_done), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_blocks_after_done", issue_cnt - base, 2);
        busy = 1'b0;
        drain(20);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        chk("done_ignored_in_idle", int'(frame_done), 0);

        // Reset while a command sits in ISSUE with five more queued.
        busy = 1'b1;
        for (int i = 0; i < 6; i++) push(4'(i + 1), 1'b1);
        busy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_valid && n < 20);
        chk("midreset_issue_seen", int'(cmd_valid), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_cmd_valid", int'(cmd_valid), 0);
        chk("midreset_fifo_count", int'(fifo_count), 0);
        chk("midreset_host_ready", int'(host_ready), 1);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_count", int'(fifo_count), 0);
        chk("post_reset_cmd", int'(cmd), 0);

        // Sustained traffic through pointer wrap with backpressure.
        base = issue_cnt;
        for (int i = 0; i < 40; i++) push_hs(4'(1 + i % 11));
        drain(200);
        chk("wrap_issue_count", issue_cnt - base, 40);
        chk("wrap_final_count", int'(fifo_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Upstream command-issue stage for the LCD image display controller. Buffers host command codes in a FIFO and presents them one at a time on the controller's `cmd`/`cmd_valid` input, honouring the controller's `busy` and `done` flags. Host software can queue a whole command script, including the terminating write command, without tracking controller timing. Invalid codes are dropped and flagged. Each completed frame write-back is reported.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, log2(DEPTH): FIFO pointer width. Derived; do not override.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `host_cmd`  in  4  command code from host.
- `host_valid`  in  1  host offers `host_cmd` this cycle.
- `host_ready`  out  1  FIFO can accept. Equals !full.
- `cmd`  out  4  registered command to the controller.
- `cmd_valid`  out  1  registered; high for exactly one cycle per issued command.
- `busy`  in  1  controller busy flag.
- `done`  in  1  controller write-back complete pulse.
- `fifo_count`  out  AW+1  entries currently queued, 0..DEPTH.
- `cmd_err`  out  1  one-cycle pulse when an invalid code (12–15) is dropped.
- `frame_done`  out  1  one-cycle pulse after `done` is seen for an issued write.

## Operation
- **Valid codes:** 0 = write/output, 1–4 = shift up/down/left/right, 5 = max, 6 = min, 7 = average, 8 = counter-clockwise rotate, 9 = clockwise rotate, 10 = mirror X, 11 = mirror Y.
- **FIFO push:** a push occurs when `host_valid && host_ready`. Codes are stored unchecked. Validation happens at pop.
- **FIFO pop:** a pop occurs only in state IDLE, when `!busy` and `fifo_count != 0`.
- **Simultaneous push and pop:** when both happen in the same cycle, `fifo_count` is unchanged.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH.
- **Full FIFO:** `host_ready` = 0. Offered data is ignored, not stored.
- **State machine:** four states, IDLE / ISSUE / GAP / WAIT_DONE.
  - **IDLE**, pop with valid code: `cmd` <= head, `cmd_valid` <= 1, go to ISSUE.
  - **IDLE**, pop with invalid code: entry discarded, `cmd_err` <= 1 for one cycle, stay IDLE.
  - **ISSUE**: `cmd_valid` <= 0. If `cmd` == 0, go to WAIT_DONE; otherwise go to GAP.
  - **GAP**: one dead cycle so the controller's `busy` response is visible. Then go to IDLE.
  - **WAIT_DONE**: no pops. On `done` == 1: `frame_done` <= 1 for one cycle, go to IDLE.
- **Value hold:** `cmd` holds its last value when `cmd_valid` = 0.
- **`busy` high in IDLE:** no pop and no issue. The post-reset image-load phase is naturally waited out.
- **`done` outside WAIT_DONE:** ignored.
- **Reset (including mid-operation):**
  - FIFO flushed, pointers 0, state IDLE.
  - `cmd` = 0, `cmd_valid` = 0, `cmd_err` = 0, `frame_done` = 0, `fifo_count` = 0, `host_ready` = 1.
  - A command in ISSUE is abandoned.

## Timing
- **Push-to-issue latency:** push accepted at edge t into an empty FIFO in IDLE with `busy` = 0 gives `cmd_valid` high from edge t+1 to edge t+2.
- **Throughput for non-write commands:** one command per 3 cycles (IDLE, ISSUE, GAP).
- **Write command:** after issuing code 0, the next pop happens no earlier than the cycle after `done` is sampled high, and only once `busy` = 0.
- **Invalid code:** a dropped code costs 1 cycle. `cmd_err` is high in the cycle after the pop edge.
- **`fifo_count`:** registered; updates on the edge of the push or pop.
- **`host_ready`:** combinational from `fifo_count`. Not dependent on the same-cycle pop.

## Test plan
- **Reset/hold:** assert `reset` with `busy` = 1 for 70 cycles, push 3, 4 → both stay queued (`fifo_count` = 2). Drop `busy` → `cmd` = 3 pulse, then 3 cycles later `cmd` = 4 pulse; each `cmd_valid` exactly 1 cycle.
- **Fill/full:** with `busy` = 1, push 17 codes (DEPTH = 16) → `host_ready` low after the 16th push, the 17th is not stored, `fifo_count` = 16. Release `busy` → 16 issues in FIFO order.
- **Invalid code:** push 5, 13, 6 with `busy` = 0 → `cmd` 5, a `cmd_err` pulse, then `cmd` 6. No `cmd_valid` for 13.
- **Write and done:** push 9, 0, 1 → 9 issued, then 0 issued. 1 is held through 64 cycles of `busy` high. The `done` pulse produces `frame_done` the next cycle, and 1 is issued once `busy` = 0.
- **Mid-operation reset:** reset asserted during ISSUE with 5 entries queued → `cmd_valid` drops immediately, `fifo_count` = 0, `host_ready` = 1.
- **Simultaneous push/pop at wrap:** push continuously for 40 cycles with `busy` = 0 → all 40 codes issued in order, and `fifo_count` never exceeds DEPTH.
